// File: rtl/pu_demux.sv
// Demultiplexer PU: loads a selector and a value from the bus, then presents
// MUX_SIZE slots, one per output-enable strobe, with only the selected slot non-zero.
module pu_demux #(
  parameter int DATA_WIDTH = 32,
  parameter int ATTR_WIDTH = 4,
  parameter int MUX_SIZE   = 4,
  parameter int SEL_WIDTH  = $clog2(MUX_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signal_load,
  input  logic                  signal_sel,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ATTR_WIDTH-1:0] attr_in,
  input  logic                  signal_oe,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ATTR_WIDTH-1:0] attr_out
);

  // state    | meaning
  // ST_EMPTY | reset state, nothing loaded or sequence fully read
  // ST_SEL   | selector held, waiting for a value
  // ST_READY | selector and value held, slots readable
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_SEL   = 2'd1,
    ST_READY = 2'd2
  } state_t;

  localparam logic [SEL_WIDTH-1:0]  LAST_SLOT    = SEL_WIDTH'(MUX_SIZE - 1);
  localparam logic [ATTR_WIDTH-1:0] ATTR_INVALID = ATTR_WIDTH'(1);

  logic                  r_load;
  logic                  r_sel;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ATTR_WIDTH-1:0] r_attr;

  state_t                r_state;
  logic [SEL_WIDTH-1:0]  r_selector;
  logic [SEL_WIDTH-1:0]  r_n;
  logic [DATA_WIDTH-1:0] r_value;
  logic [ATTR_WIDTH-1:0] r_vattr;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic [ATTR_WIDTH-1:0] r_attr_out;

  state_t                w_state_nxt;
  logic [SEL_WIDTH-1:0]  w_selector_nxt;
  logic [SEL_WIDTH-1:0]  w_n_nxt;
  logic [DATA_WIDTH-1:0] w_value_nxt;
  logic [ATTR_WIDTH-1:0] w_vattr_nxt;
  logic [DATA_WIDTH-1:0] w_data_out_nxt;
  logic [ATTR_WIDTH-1:0] w_attr_out_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_load <= 1'b0;
      r_sel  <= 1'b0;
      r_data <= '0;
      r_attr <= '0;
    end else begin
      r_load <= signal_load;
      r_sel  <= signal_load & signal_sel;
      r_data <= data_in;
      r_attr <= attr_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_selector <= '0;
      r_n        <= '0;
      r_value    <= '0;
      r_vattr    <= '0;
      r_data_out <= '0;
      r_attr_out <= '0;
    end else begin
      r_selector <= w_selector_nxt;
      r_n        <= w_n_nxt;
      r_value    <= w_value_nxt;
      r_vattr    <= w_vattr_nxt;
      r_data_out <= w_data_out_nxt;
      r_attr_out <= w_attr_out_nxt;
    end
  end

  // Read is resolved first on the pre-commit state; a committing load then
  // overrides, so a selector load beats the wrap of the last slot.
  always_comb begin
    w_state_nxt    = r_state;
    w_selector_nxt = r_selector;
    w_n_nxt        = r_n;
    w_value_nxt    = r_value;
    w_vattr_nxt    = r_vattr;
    w_data_out_nxt = '0;
    w_attr_out_nxt = '0;

    if (signal_oe) begin
      if (r_state == ST_READY) begin
        if (r_n == r_selector) begin
          w_data_out_nxt = r_value;
          w_attr_out_nxt = r_vattr;
        end
        if (r_n == LAST_SLOT) begin
          w_n_nxt     = '0;
          w_state_nxt = ST_EMPTY;
        end else begin
          w_n_nxt = r_n + SEL_WIDTH'(1);
        end
      end else begin
        w_attr_out_nxt = ATTR_INVALID;
      end
    end

    if (r_sel) begin
      w_selector_nxt = r_data[SEL_WIDTH-1:0];
      w_n_nxt        = '0;
      w_state_nxt    = ST_SEL;
    end else if (r_load && (r_state != ST_EMPTY)) begin
      w_value_nxt = r_data;
      w_vattr_nxt = r_attr;
      w_state_nxt = ST_READY;
    end
  end

  assign data_out = r_data_out;
  assign attr_out = r_attr_out;

endmodule
